procb_state_restore: RTL
========================

# procb_state_restore

Reader/unpacker for the per-thread process_bytes saved-state memory. When the md5 engine resumes a thread, this block reads that thread's saved record, replays the pending padded bytes as a byte stream, and reports bytes_total and the finish flag. It then writes the record back with its valid bit cleared, so each saved state is consumed exactly once. It sits between the thread scheduler and the process_bytes input stage, alongside the saved-state memory's write port.

## Interface
Parameters:
- N_THREADS, 6, number of threads.
- N_THREADS_MSB, `MSB(N_THREADS-1), thread index MSB.
- SAVE_WIDTH, 82, record width; must be ≥82.

Ports:
- CLK  in  1  clock.
- RESET_N  in  1  synchronous, active-low reset.
- req_valid  in  1  restore request.
- req_thread_num  in  N_THREADS_MSB+1  thread to restore.
- req_ready  out  1  request accepted when high together with req_valid.
- rd_thread_num  out  N_THREADS_MSB+1  registered address to memory (async read).
- rd_dout  in  SAVE_WIDTH  memory read data.
- snoop_wr_en, snoop_wr_thread_num, snoop_din  in  1 / N_THREADS_MSB+1 / SAVE_WIDTH  copy of the memory write port, used for bypass.
- out_valid, out_ready, out_byte[7:0], out_last  out/in/out/out  pending-byte stream.
- info_valid  out  1  one-cycle summary strobe.
- info_empty  out  1  record was not valid.
- info_fin  out  1  finish flag.
- info_bytes_total  out  12  saved bytes_total.
- clr_wr_en, clr_thread_num, clr_din  out  1 / N_THREADS_MSB+1 / SAVE_WIDTH  write-back of the consumed record.
- err  out  1  sticky protocol error.

## Operation
- Record layout (LSB up):
  - [0] valid
  - [1] fin
  - [13:2] bytes_total
  - [17:14] npend (0..8)
  - [81:18] pend_data, with byte k at [18+8k +:8]
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch thr=req_thread_num and rd_thread_num=req_thread_num, then go to LOAD.
  - LOAD: capture rec=rd_dout.
    - Bypass: if snoop_wr_en and snoop_wr_thread_num==thr in this same cycle, capture snoop_din instead.
    - If rec.valid=0, go to SUMMARY.
    - Else if npend=0, go to SUMMARY.
    - Else set idx=0 and go to EMIT.
  - EMIT: out_valid=1, out_byte=pend_data byte idx, out_last=(idx==npend-1).
    - On out_ready, increment idx.
    - On out_ready with out_last, go to SUMMARY.
  - SUMMARY: one cycle, then IDLE.
    - Assert info_valid with info_empty=~rec.valid, info_fin, info_bytes_total.
    - If rec.valid, also assert clr_wr_en with clr_thread_num=thr and clr_din=rec with bit 0 cleared.
- npend>8 in a valid record is treated as 8 and sets err.
- A snoop write to thr during EMIT or SUMMARY is a protocol violation: set err; rec is not updated.
- err clears only on reset.
- The parent muxes clr_* into the memory write port and guarantees acceptance in that same cycle.

## Timing
- Reset (RESET_N low at a CLK edge), including mid-operation:
  - state→IDLE
  - out_valid, out_last, info_valid, clr_wr_en, err, rd_thread_num, idx, rec all cleared to 0
  - any stream in progress is abandoned with no write-back
  - req_ready=0 while RESET_N is low
- Request accepted at cycle 0 → LOAD at cycle 1 → first out_valid at cycle 2.
- Valid record with npend=n and out_ready held high: last byte at cycle 1+n, info_valid/clr_wr_en at cycle 2+n, req_ready again at cycle 3+n.
- Empty or npend=0 record: info_valid at cycle 2, IDLE at cycle 3.
- out_byte and out_last hold stable while out_valid && !out_ready.
- info_* and clr_* are valid only in the info_valid cycle and are 0 otherwise.

## Test plan
- Record thr=3, valid=1, fin=0, bytes_total=0x040, npend=3, data bytes 0x80,0x00,0x00; out_ready=1 → bytes 0x80,0x00,0x00 on cycles 2–4 with out_last on cycle 4; info at cycle 5 with bytes_total=0x040, fin=0; clr_wr_en=1, thr=3, clr_din bit 0=0.
- Record valid=0 for thr=0 → no out_valid; info_valid at cycle 2 with info_empty=1; clr_wr_en=0.
- npend=2, out_ready toggling 1,0,0,1 → each byte held across stall cycles; exactly 2 beats transferred.
- Snoop write of a new record to thr in the LOAD cycle → new record's values emitted, not rd_dout's.
- Snoop write to thr during EMIT → err=1 and stays 1; stream completes with the original data.
- RESET_N low during EMIT → next cycle out_valid=0, err=0, no clr_wr_en; after release req_ready=1, and a new request restores correctly.

Source files
------------

// File: rtl/procb_state_restore.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : procb_state_restore
//  Purpose  : Reader/unpacker for the per-thread process_bytes saved-state
//             memory. On a restore request it reads the thread's saved record.
//             It replays the pending padded bytes as a byte stream and reports
//             bytes_total and the finish flag. It then writes the record back
//             with its valid bit cleared, so each saved state is consumed once.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK                  in   clock
//    RESET_N              in   synchronous active-low reset
//    req_valid            in   restore request
//    req_thread_num       in   thread to restore
//    req_ready            out  request accepted when high with req_valid
//    rd_thread_num        out  registered read address (async-read memory)
//    rd_dout              in   memory read data
//    snoop_wr_en          in   copy of memory write enable (bypass / check)
//    snoop_wr_thread_num  in   copy of memory write address
//    snoop_din            in   copy of memory write data
//    out_valid            out  pending-byte stream valid
//    out_ready            in   pending-byte stream ready
//    out_byte             out  pending byte
//    out_last             out  last pending byte of the record
//    info_valid           out  one-cycle summary strobe
//    info_empty           out  restored record was not valid
//    info_fin             out  saved finish flag
//    info_bytes_total     out  saved bytes_total
//    clr_wr_en            out  write-back of the consumed record
//    clr_thread_num       out  write-back address
//    clr_din              out  write-back data (valid bit cleared)
//    err                  out  sticky protocol error
// ----------------------------------------------------------------------------
//  Record layout (LSB up):
//    [0] valid, [1] fin, [13:2] bytes_total, [17:14] npend (0..8),
//    [81:18] pend_data with byte k at [18+8k +: 8]
// ============================================================================
module procb_state_restore #(
   parameter int N_THREADS     = 6,
   parameter int N_THREADS_MSB = (N_THREADS > 1) ? $clog2(N_THREADS) - 1 : 0,
   parameter int SAVE_WIDTH    = 82
) (
   input  logic                     CLK,
   input  logic                     RESET_N,
   // restore request from the thread scheduler
   input  logic                     req_valid,
   input  logic [N_THREADS_MSB:0]   req_thread_num,
   output logic                     req_ready,
   // saved-state memory read port
   output logic [N_THREADS_MSB:0]   rd_thread_num,
   input  logic [SAVE_WIDTH-1:0]    rd_dout,
   // copy of the saved-state memory write port
   input  logic                     snoop_wr_en,
   input  logic [N_THREADS_MSB:0]   snoop_wr_thread_num,
   input  logic [SAVE_WIDTH-1:0]    snoop_din,
   // pending-byte stream
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [7:0]               out_byte,
   output logic                     out_last,
   // restore summary
   output logic                     info_valid,
   output logic                     info_empty,
   output logic                     info_fin,
   output logic [11:0]              info_bytes_total,
   // write-back of the consumed record
   output logic                     clr_wr_en,
   output logic [N_THREADS_MSB:0]   clr_thread_num,
   output logic [SAVE_WIDTH-1:0]    clr_din,
   // sticky protocol error
   output logic                     err
);

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LOAD    = 2'd1;
   localparam logic [1:0] S_EMIT    = 2'd2;
   localparam logic [1:0] S_SUMMARY = 2'd3;

   // Largest number of pending bytes a record can carry.
   localparam logic [3:0] c_MAX_PEND = 4'd8;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [1:0]              r_state;
   logic [N_THREADS_MSB:0]  r_thr;
   logic [N_THREADS_MSB:0]  r_rd_thread_num;
   logic [SAVE_WIDTH-1:0]   r_rec;
   logic [3:0]              r_npend;     // effective (clamped) pending count
   logic [2:0]              r_idx;       // byte being presented on the stream
   logic                    r_err;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic                    w_snoop_hit;
   logic [SAVE_WIDTH-1:0]   w_load_rec;
   logic                    w_load_valid;
   logic [3:0]              w_load_npend;
   logic                    w_load_over;
   logic [3:0]              w_load_npend_eff;
   logic [63:0]             w_pend_data;
   logic                    w_emit;
   logic                    w_summary;
   logic                    w_last;
   logic                    w_clr;

   // A write to the thread being restored, seen on the memory write port.
   assign w_snoop_hit = snoop_wr_en && (snoop_wr_thread_num == r_thr);

   // During LOAD the async read still shows the old contents if the memory
   // is being written in the same cycle, so the in-flight write data wins.
   assign w_load_rec       = w_snoop_hit ? snoop_din : rd_dout;
   assign w_load_valid     = w_load_rec[0];
   assign w_load_npend     = w_load_rec[17:14];
   assign w_load_over      = w_load_valid && (w_load_npend > c_MAX_PEND);
   assign w_load_npend_eff = w_load_over ? c_MAX_PEND : w_load_npend;

   assign w_pend_data = r_rec[81:18];
   assign w_emit      = (r_state == S_EMIT);
   assign w_summary   = (r_state == S_SUMMARY);

   // r_npend is at least 1 whenever EMIT is reachable, so the subtraction
   // cannot wrap while the comparison matters.
   assign w_last = ({1'b0, r_idx} == (r_npend - 4'd1));

   // Only a record that was actually valid is consumed and written back.
   assign w_clr = w_summary && r_rec[0];

   // ------------------------------------------------------------------------
   // Control FSM and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         r_state         <= S_IDLE;
         r_thr           <= '0;
         r_rd_thread_num <= '0;
         r_rec           <= '0;
         r_npend         <= '0;
         r_idx           <= '0;
         r_err           <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_thr           <= req_thread_num;
                  r_rd_thread_num <= req_thread_num;
                  r_state         <= S_LOAD;
               end
            end

            S_LOAD: begin
               r_rec   <= w_load_rec;
               r_npend <= w_load_npend_eff;
               r_idx   <= 3'd0;
               if (w_load_over) begin
                  r_err <= 1'b1;
               end
               if (!w_load_valid || (w_load_npend == 4'd0)) begin
                  r_state <= S_SUMMARY;
               end else begin
                  r_state <= S_EMIT;
               end
            end

            S_EMIT: begin
               // The captured record is owned by this block until the
               // write-back; a foreign write now would be silently lost.
               if (w_snoop_hit) begin
                  r_err <= 1'b1;
               end
               if (out_ready) begin
                  if (w_last) begin
                     r_state <= S_SUMMARY;
                  end else begin
                     r_idx <= r_idx + 3'd1;
                  end
               end
            end

            S_SUMMARY: begin
               if (w_snoop_hit) begin
                  r_err <= 1'b1;
               end
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign req_ready     = RESET_N && (r_state == S_IDLE);
   assign rd_thread_num = r_rd_thread_num;

   // Byte and last flag depend only on registers, so they hold steady while
   // the consumer stalls.
   assign out_valid = w_emit;
   assign out_byte  = w_emit ? w_pend_data[{r_idx, 3'b000} +: 8] : 8'h00;
   assign out_last  = w_emit && w_last;

   assign info_valid       = w_summary;
   assign info_empty       = w_summary && !r_rec[0];
   assign info_fin         = w_summary && r_rec[1];
   assign info_bytes_total = w_summary ? r_rec[13:2] : 12'h000;

   assign clr_wr_en      = w_clr;
   assign clr_thread_num = w_clr ? r_thr : '0;
   assign clr_din        = w_clr ? {r_rec[SAVE_WIDTH-1:1], 1'b0} : '0;

   assign err = r_err;

endmodule
`default_nettype wire
